// File: rtl/comp_multiplier_if.sv
// Start/operand/result signal bundle between a requester and comp_multiplier.
interface comp_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 Run;
  logic [WIDTH-1:0]     Multiplicand_in;
  logic [WIDTH-1:0]     Multiplier_in;
  logic [2*WIDTH-1:0]   Product_out;
  logic                 Ready;

  modport master (
    output Run, Multiplicand_in, Multiplier_in,
    input  Product_out, Ready
  );

  modport slave (
    input  Run, Multiplicand_in, Multiplier_in,
    output Product_out, Ready
  );
endinterface

// File: rtl/comp_multiplier.sv
// Sequential shift-add unsigned multiplier: one partial product per cycle over
// WIDTH cycles, then a one-cycle Ready pulse. WIDTH must be at least 2.
module comp_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                Reset,
  comp_multiplier_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     mcand_reg;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       partial;
  logic                 last_iter;

  // Upper half plus multiplicand at WIDTH+1 bits keeps the carry for the shift.
  always_comb begin
    if (prod[0]) begin
      partial = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand_reg};
    end else begin
      partial = {1'b0, prod[2*WIDTH-1:WIDTH]};
    end
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Run) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the datapath is reset too, so Product_out reads 0 until the first result.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      cnt       <= '0;
      mcand_reg <= '0;
      prod      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Run) begin
            mcand_reg <= bus.Multiplicand_in;
            prod      <= {{WIDTH{1'b0}}, bus.Multiplier_in};
            cnt       <= '0;
          end
        end
        CALC: begin
          prod <= {partial, prod[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.Ready       = (state == DONE);
    bus.Product_out = prod;
  end

endmodule

// File: tb/tb_comp_multiplier.sv
// Randomized and directed checks of comp_multiplier against a plain a*b model.
module tb_comp_multiplier;

  localparam int WIDTH = 32;

  logic clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  comp_multiplier_if #(.WIDTH(WIDTH)) bus ();

  comp_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation with a single-cycle Run pulse; operands are scrambled after
  // the start edge. With glitch set, a second Run is pulsed in CALC cycle 10.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit glitch);
    logic [63:0] exp;
    logic [63:0] result;
    int          latency;
    int          pulses;
    exp     = 64'(a) * 64'(b);
    result  = '0;
    latency = 0;
    pulses  = 0;
    @(negedge clk);
    bus.Run             = 1'b1;
    bus.Multiplicand_in = a;
    bus.Multiplier_in   = b;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.Run             = 1'b0;
        bus.Multiplicand_in = $urandom;
        bus.Multiplier_in   = $urandom;
      end
      if (glitch && i == 10) begin
        bus.Run             = 1'b1;
        bus.Multiplicand_in = $urandom;
        bus.Multiplier_in   = $urandom;
      end else if (glitch && i == 11) begin
        bus.Run = 1'b0;
      end
      if (bus.Ready) begin
        pulses++;
        if (pulses == 1) begin
          latency = i;
          result  = bus.Product_out;
        end
      end
    end
    check({tag, " latency"}, 64'(latency), 64'(WIDTH + 1));
    check({tag, " product"}, result, exp);
    check({tag, " ready_pulses"}, 64'(pulses), 64'd1);
    check({tag, " held"}, bus.Product_out, exp);
  endtask

  logic [63:0] exp_q[$];

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    Reset               = 1'b0;
    bus.Run             = 1'b0;
    bus.Multiplicand_in = '0;
    bus.Multiplier_in   = '0;
    repeat (3) @(negedge clk);
    check("reset ready", 64'(bus.Ready), 64'd0);
    check("reset product", bus.Product_out, 64'd0);
    Reset = 1'b1;

    run_op("3x5", 32'd3, 32'd5, 1'b0);
    run_op("max x max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("0 x 12345678", 32'd0, 32'h1234_5678, 1'b0);
    run_op("12345678 x 1", 32'h1234_5678, 32'd1, 1'b0);
    run_op("7x9 ignored rerun", 32'd7, 32'd9, 1'b1);
    for (int k = 0; k < 4; k++) run_op("random", $urandom, $urandom, 1'b0);

    // Reset in the middle of CALC
    @(negedge clk);
    bus.Run             = 1'b1;
    bus.Multiplicand_in = 32'hFFFF;
    bus.Multiplier_in   = 32'hFFFF;
    @(negedge clk);
    bus.Run = 1'b0;
    repeat (14) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    check("midcalc reset ready", 64'(bus.Ready), 64'd0);
    check("midcalc reset product", bus.Product_out, 64'd0);
    Reset = 1'b1;
    run_op("2x3 after reset", 32'd2, 32'd3, 1'b0);

    // Reset wins over a simultaneous Run
    Reset               = 1'b0;
    bus.Run             = 1'b1;
    bus.Multiplicand_in = 32'd9;
    bus.Multiplier_in   = 32'h55;
    @(negedge clk);
    check("reset over run", bus.Product_out, 64'd0);
    Reset   = 1'b1;
    bus.Run = 1'b0;
    repeat (3) @(negedge clk);
    check("idle holds zero", bus.Product_out, 64'd0);
    check("idle ready low", 64'(bus.Ready), 64'd0);

    // Back-to-back with Run held high; new operands presented at each Ready
    bus.Run             = 1'b1;
    bus.Multiplicand_in = $urandom;
    bus.Multiplier_in   = $urandom;
    exp_q.push_back(64'(bus.Multiplicand_in) * 64'(bus.Multiplier_in));
    for (int k = 0; k < 1000; k++) begin
      int cyc;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!bus.Ready && cyc < 40);
      check("b2b period", 64'(cyc), (k == 0) ? 64'(WIDTH + 1) : 64'(WIDTH + 2));
      check("b2b product", bus.Product_out, exp_q.pop_front());
      if (k < 999) begin
        bus.Multiplicand_in = $urandom;
        bus.Multiplier_in   = $urandom;
        exp_q.push_back(64'(bus.Multiplicand_in) * 64'(bus.Multiplier_in));
      end else begin
        bus.Run = 1'b0;
      end
    end
    repeat (40) @(negedge clk);
    check("b2b stops", 64'(bus.Ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
